// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Result registers hold the last conversion so the display never sees partial digits.
module bin_to_bcd_seq #(
    parameter int WIDTH    = 16,
    parameter int SATURATE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] binary,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [39:0]      scratch_reg;
    logic [39:0]      scratch_adj;
    logic [CW-1:0]    count_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             overflow_reg;
    logic [15:0]      bcd_reg;
    logic             overflow_calc;
    logic [15:0]      bcd_calc;

    // Per-digit add-3 correction; digits never exceed 9 after the shift, so no inter-digit carry.
    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_digit
            assign scratch_adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                          ? scratch_reg[gi*4 +: 4] + 4'd3
                                          : scratch_reg[gi*4 +: 4];
        end
    endgenerate

    assign overflow_calc = |scratch_reg[39:16];
    assign bcd_calc      = (overflow_calc && (SATURATE != 0)) ? 16'h9999 : scratch_reg[15:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count_reg == CW'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy stays high through the done cycle, which is spent in IDLE so a held start re-arms at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg    <= '0;
            scratch_reg  <= '0;
            count_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            bcd_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            busy_reg <= (state_next != IDLE) || (state_reg == FINISH);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg   <= binary;
                        scratch_reg <= '0;
                        count_reg   <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    {scratch_reg, shift_reg} <= {scratch_adj, shift_reg} << 1;
                    count_reg                <= count_reg - 1'b1;
                end
                FINISH: begin
                    overflow_reg <= overflow_calc;
                    bcd_reg      <= bcd_calc;
                    done_reg     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign bcd      = bcd_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: saturating and wrapping instances share stimulus.
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [15:0] val;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] binary = '0;
    logic        busy_s, done_s, ovf_s;
    logic        busy_n, done_n, ovf_n;
    logic [15:0] bcd_s, bcd_n;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q_s[$];
    exp_t q_n[$];

    always #5 clock = ~clock;

    bin_to_bcd_seq #(.WIDTH(16), .SATURATE(1)) dut_s (
        .clock(clock), .reset_n(reset_n), .start(start), .binary(binary),
        .busy(busy_s), .done(done_s), .bcd(bcd_s), .overflow(ovf_s)
    );

    bin_to_bcd_seq #(.WIDTH(16), .SATURATE(0)) dut_n (
        .clock(clock), .reset_n(reset_n), .start(start), .binary(binary),
        .busy(busy_n), .done(done_n), .bcd(bcd_n), .overflow(ovf_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division, independent of the shift-add structure.
    function automatic logic [15:0] dec4(input int unsigned v);
        int unsigned r;
        r = v % 10000;
        return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    task automatic push(input logic [15:0] v, input logic [15:0] e_sat,
                        input logic [15:0] e_wrap, input logic e_ovf);
        exp_t e;
        e.val = v; e.ovf = e_ovf;
        e.bcd = e_sat;  q_s.push_back(e);
        e.bcd = e_wrap; q_n.push_back(e);
    endtask

    task automatic push_model(input logic [15:0] v);
        logic o;
        o = (v > 16'd9999);
        push(v, o ? 16'h9999 : dec4(v), dec4(v), o);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clock);
        while (busy_s && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (k >= 100) chk("idle_timeout", 32'(busy_s), 32'd0);
    endtask

    // Issue one start pulse; returns 1ns after the accepting edge.
    task automatic issue(input logic [15:0] v, input logic [15:0] e_sat,
                         input logic [15:0] e_wrap, input logic e_ovf);
        wait_idle();
        binary = v;
        start  = 1'b1;
        push(v, e_sat, e_wrap, e_ovf);
        @(posedge clock);
        #1;
        start  = 1'b0;
        binary = 16'($urandom);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (done_s) begin
            if (q_s.size() == 0) begin
                chk("unexpected_done_sat", 32'(bcd_s), 32'hFFFF_FFFF);
            end else begin
                e = q_s.pop_front();
                $display("sat  in=%0d bcd=%h ovf=%0b", e.val, bcd_s, ovf_s);
                chk("bcd_sat", 32'(bcd_s), 32'(e.bcd));
                chk("ovf_sat", 32'(ovf_s), 32'(e.ovf));
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (done_n) begin
            if (q_n.size() == 0) begin
                chk("unexpected_done_wrap", 32'(bcd_n), 32'hFFFF_FFFF);
            end else begin
                e = q_n.pop_front();
                $display("wrap in=%0d bcd=%h ovf=%0b", e.val, bcd_n, ovf_n);
                chk("bcd_wrap", 32'(bcd_n), 32'(e.bcd));
                chk("ovf_wrap", 32'(ovf_n), 32'(e.ovf));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int done_k;
        int busy_cnt;
        logic [15:0] v;

        #13;
        chk("rst_busy", 32'(busy_s), 32'd0);
        chk("rst_done", 32'(done_s), 32'd0);
        chk("rst_bcd",  32'(bcd_s),  32'd0);
        chk("rst_ovf",  32'(ovf_s),  32'd0);
        @(posedge clock);
        #3;
        reset_n = 1'b1;

        // Latency and busy window for a single conversion.
        issue(16'd1234, 16'h1234, 16'h1234, 1'b0);
        chk("busy_after_accept", 32'(busy_s), 32'd1);
        done_k   = -1;
        busy_cnt = 1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clock);
            #1;
            if (done_s && done_k < 0) done_k = k;
            if (busy_s) busy_cnt++;
            else break;
        end
        chk("done_latency", 32'(done_k), 32'd17);
        chk("busy_cycles", 32'(busy_cnt), 32'd18);

        issue(16'd0,     16'h0000, 16'h0000, 1'b0);
        issue(16'd9999,  16'h9999, 16'h9999, 1'b0);
        issue(16'd10000, 16'h9999, 16'h0000, 1'b1);
        issue(16'hFFFF,  16'h9999, 16'h5535, 1'b1);
        wait_idle();

        // Fresh reset so the held-value check below sees 0x0000.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;

        // Start during busy is ignored.
        issue(16'd42, 16'h0042, 16'h0042, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        chk("hold_bcd_mid", 32'(bcd_s), 32'h0000);
        start  = 1'b1;
        binary = 16'd77;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        chk("hold_bcd_late", 32'(bcd_s), 32'h0000);
        wait_idle();

        // Asynchronous reset mid-conversion.
        issue(16'd9876, 16'h9876, 16'h9876, 1'b0);
        repeat (7) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_s), 32'd0);
        chk("arst_done", 32'(done_s), 32'd0);
        chk("arst_bcd",  32'(bcd_s),  32'd0);
        chk("arst_ovf",  32'(ovf_s),  32'd0);
        q_s.delete();
        q_n.delete();
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
        issue(16'd9876, 16'h9876, 16'h9876, 1'b0);
        wait_idle();

        // Free-running refresh: start held, binary steps each cycle, accepts every 18 edges.
        for (int i = 0; i < 18 * 5; i++) begin
            @(negedge clock);
            binary = 16'(i);
            start  = 1'b1;
            if (i % 18 == 0) push_model(16'(i));
        end
        @(negedge clock);
        start = 1'b0;
        wait_idle();

        for (int r = 0; r < 1000; r++) begin
            v = 16'($urandom);
            issue(v, (v > 16'd9999) ? 16'h9999 : dec4(v), dec4(v), v > 16'd9999);
        end
        wait_idle();
        repeat (3) @(negedge clock);
        chk("queue_empty_sat",  32'(q_s.size()), 32'd0);
        chk("queue_empty_wrap", 32'(q_n.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
